// File: rtl/sodor_dmem_responder_if.sv
// Request/response bundle between the Sodor core's dmem port and a data-memory responder.
// The core drives the request fields and the responder drives the handshake and response fields.
interface sodor_dmem_responder_if;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        req_fcn;
  logic [2:0]  req_typ;
  logic        req_valid;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        err;

  modport master (
    output req_addr, req_data, req_fcn, req_typ, req_valid,
    input  req_ready, resp_valid, resp_data, err
  );

  modport slave (
    input  req_addr, req_data, req_fcn, req_typ, req_valid,
    output req_ready, resp_valid, resp_data, err
  );
endinterface

// File: rtl/sodor_dmem_responder.sv
// Sodor dmem responder: word-organised RAM with byte-masked stores and sign/zero-extended
// loads, answered one request at a time after a fixed LATENCY through an IDLE/BUSY/RESP FSM.
module sodor_dmem_responder_core #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 1
) (
  input logic                  clk_i,
  input logic                  rst_i,
  sodor_dmem_responder_if.slave dmem
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  localparam logic [2:0] TYP_B  = 3'd1;
  localparam logic [2:0] TYP_H  = 3'd2;
  localparam logic [2:0] TYP_W  = 3'd3;
  localparam logic [2:0] TYP_BU = 3'd5;
  localparam logic [2:0] TYP_HU = 3'd6;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          out_of_range;
  logic          bad_typ;
  logic          misaligned;
  logic          req_err;
  logic          do_write;
  logic [3:0]    be;
  logic [31:0]   wword;
  logic [31:0]   rword;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [31:0]   load_val;

  assign accept = (state_q == IDLE) && dmem.req_valid;

  // Address decode and error classification; wrapped offsets below BASE_ADDR are caught explicitly.
  always_comb begin
    offset       = dmem.req_addr - BASE_ADDR;
    idx          = offset[AW+1:2];
    lane         = offset[1:0];
    out_of_range = (dmem.req_addr < BASE_ADDR) || (|offset[31:AW+2]);
    bad_typ      = !(dmem.req_typ inside {TYP_B, TYP_H, TYP_W, TYP_BU, TYP_HU});
    misaligned   = ((dmem.req_typ == TYP_H || dmem.req_typ == TYP_HU) && lane[0]) ||
                   ((dmem.req_typ == TYP_W) && (lane != 2'd0));
    req_err      = out_of_range || bad_typ || misaligned;
  end

  always_comb begin
    be    = '0;
    wword = '0;
    unique case (dmem.req_typ)
      TYP_B, TYP_BU: begin
        be    = 4'b0001 << lane;
        wword = {4{dmem.req_data[7:0]}};
      end
      TYP_H, TYP_HU: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{dmem.req_data[15:0]}};
      end
      TYP_W: begin
        be    = 4'b1111;
        wword = dmem.req_data;
      end
      default: begin
        be    = '0;
        wword = '0;
      end
    endcase
  end

  always_comb begin
    rword    = mem[idx];
    rbyte    = 8'(rword >> {lane, 3'b000});
    rhalf    = lane[1] ? rword[31:16] : rword[15:0];
    load_val = '0;
    unique case (dmem.req_typ)
      TYP_B:   load_val = {{24{rbyte[7]}}, rbyte};
      TYP_BU:  load_val = {24'd0, rbyte};
      TYP_H:   load_val = {{16{rhalf[15]}}, rhalf};
      TYP_HU:  load_val = {16'd0, rhalf};
      TYP_W:   load_val = rword;
      default: load_val = '0;
    endcase
  end

  // Reset has priority over a same-cycle request, so nothing is committed while it is high.
  assign do_write = accept && dmem.req_fcn && !req_err && !rst_i;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    rdata_d         = rdata_q;
    err_d           = err_q;
    dmem.req_ready  = 1'b0;
    dmem.resp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        dmem.req_ready = 1'b1;
        if (dmem.req_valid) begin
          rdata_d = (req_err || dmem.req_fcn) ? '0 : load_val;
          err_d   = req_err;
          cnt_d   = CNT_INIT;
          state_d = (LATENCY > 1) ? BUSY : RESP;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CW'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        dmem.resp_valid = 1'b1;
        state_d         = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_write) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[idx][8*b +: 8] <= wword[8*b +: 8];
        end
      end
    end
  end

  assign dmem.resp_data = rdata_q;
  assign dmem.err       = err_q;
endmodule

module sodor_dmem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dmem_in_io_dmem_req_bits_addr,
  input  logic [31:0] dmem_in_io_dmem_req_bits_data,
  input  logic        dmem_in_io_dmem_req_bits_fcn,
  input  logic [2:0]  dmem_in_io_dmem_req_bits_typ,
  input  logic        dmem_in_io_dmem_req_valid,
  output logic        dmem_ou_io_dmem_req_ready,
  output logic        dmem_ou_io_dmem_resp_valid,
  output logic [31:0] dmem_ou_io_dmem_resp_bits_data,
  output logic        dmem_ou_err
);
  sodor_dmem_responder_if bus ();

  assign bus.req_addr  = dmem_in_io_dmem_req_bits_addr;
  assign bus.req_data  = dmem_in_io_dmem_req_bits_data;
  assign bus.req_fcn   = dmem_in_io_dmem_req_bits_fcn;
  assign bus.req_typ   = dmem_in_io_dmem_req_bits_typ;
  assign bus.req_valid = dmem_in_io_dmem_req_valid;

  assign dmem_ou_io_dmem_req_ready      = bus.req_ready;
  assign dmem_ou_io_dmem_resp_valid     = bus.resp_valid;
  assign dmem_ou_io_dmem_resp_bits_data = bus.resp_data;
  assign dmem_ou_err                    = bus.err;

  sodor_dmem_responder_core #(
    .DEPTH     (DEPTH),
    .BASE_ADDR (BASE_ADDR),
    .LATENCY   (LATENCY)
  ) u_core (
    .clk_i (clock),
    .rst_i (reset),
    .dmem  (bus)
  );
endmodule

// File: tb/tb_sodor_dmem_responder.sv
// Directed bench for sodor_dmem_responder: one instance at LATENCY=1/BASE=0 and one at
// LATENCY=3/BASE=0x1000, both with a 64-word RAM.
module tb_sodor_dmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sodor_dmem_responder_if bus1 ();
  sodor_dmem_responder_if bus3 ();

  sodor_dmem_responder #(
    .DEPTH     (64),
    .BASE_ADDR (32'h0000_0000),
    .LATENCY   (1)
  ) dut1 (
    .clock                          (clk),
    .reset                          (rst),
    .dmem_in_io_dmem_req_bits_addr  (bus1.req_addr),
    .dmem_in_io_dmem_req_bits_data  (bus1.req_data),
    .dmem_in_io_dmem_req_bits_fcn   (bus1.req_fcn),
    .dmem_in_io_dmem_req_bits_typ   (bus1.req_typ),
    .dmem_in_io_dmem_req_valid      (bus1.req_valid),
    .dmem_ou_io_dmem_req_ready      (bus1.req_ready),
    .dmem_ou_io_dmem_resp_valid     (bus1.resp_valid),
    .dmem_ou_io_dmem_resp_bits_data (bus1.resp_data),
    .dmem_ou_err                    (bus1.err)
  );

  sodor_dmem_responder #(
    .DEPTH     (64),
    .BASE_ADDR (32'h0000_1000),
    .LATENCY   (3)
  ) dut3 (
    .clock                          (clk),
    .reset                          (rst),
    .dmem_in_io_dmem_req_bits_addr  (bus3.req_addr),
    .dmem_in_io_dmem_req_bits_data  (bus3.req_data),
    .dmem_in_io_dmem_req_bits_fcn   (bus3.req_fcn),
    .dmem_in_io_dmem_req_bits_typ   (bus3.req_typ),
    .dmem_in_io_dmem_req_valid      (bus3.req_valid),
    .dmem_ou_io_dmem_req_ready      (bus3.req_ready),
    .dmem_ou_io_dmem_resp_valid     (bus3.resp_valid),
    .dmem_ou_io_dmem_resp_bits_data (bus3.resp_data),
    .dmem_ou_err                    (bus3.err)
  );

  // One LATENCY=1 transaction: returns what is seen in the cycle after accept and one cycle later.
  task automatic xact1(input logic fcn, input logic [2:0] typ, input logic [31:0] addr,
                       input logic [31:0] data, output logic rv, output logic [31:0] d,
                       output logic e, output logic rdy, output logic rdy_next);
    bus1.req_fcn   = fcn;
    bus1.req_typ   = typ;
    bus1.req_addr  = addr;
    bus1.req_data  = data;
    bus1.req_valid = 1'b1;
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    rv  = bus1.resp_valid;
    d   = bus1.resp_data;
    e   = bus1.err;
    rdy = bus1.req_ready;
    @(posedge clk); #1;
    rdy_next = bus1.req_ready;
  endtask

  // One LATENCY=3 transaction with a bounded wait; lat is the sample index of resp_valid after accept.
  task automatic xact3(input logic fcn, input logic [2:0] typ, input logic [31:0] addr,
                       input logic [31:0] data, output logic seen, output logic [31:0] d,
                       output logic e, output int lat);
    bus3.req_fcn   = fcn;
    bus3.req_typ   = typ;
    bus3.req_addr  = addr;
    bus3.req_data  = data;
    bus3.req_valid = 1'b1;
    @(posedge clk); #1;
    bus3.req_valid = 1'b0;
    seen = 1'b0;
    d    = '0;
    e    = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 8 && !seen; k++) begin
      if (bus3.resp_valid) begin
        seen = 1'b1;
        lat  = k;
        d    = bus3.resp_data;
        e    = bus3.err;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus1.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready1: got %b, expected 1", bus1.req_ready); end
    checks++; if (bus1.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_rv1: got %b, expected 0", bus1.resp_valid); end
    checks++; if (bus1.resp_data !== 32'h0) begin errors++; $display("FAIL reset_data1: got %h, expected 00000000", bus1.resp_data); end
    checks++; if (bus1.err !== 1'b0) begin errors++; $display("FAIL reset_err1: got %b, expected 0", bus1.err); end
    checks++; if (bus3.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready3: got %b, expected 1", bus3.req_ready); end
    checks++; if (bus3.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_rv3: got %b, expected 0", bus3.resp_valid); end
    checks++; if (bus3.resp_data !== 32'h0) begin errors++; $display("FAIL reset_data3: got %h, expected 00000000", bus3.resp_data); end
    checks++; if (bus3.err !== 1'b0) begin errors++; $display("FAIL reset_err3: got %b, expected 0", bus3.err); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    logic rv, e, rdy, rdyn;
    logic [31:0] d;
    xact1(1'b1, 3'd3, 32'h40, 32'hDEADBEEF, rv, d, e, rdy, rdyn);
    checks++; if (rv !== 1'b1) begin errors++; $display("FAIL sw_rv: got %b, expected 1", rv); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL sw_data: got %h, expected 00000000", d); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL sw_err: got %b, expected 0", e); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL sw_ready_resp: got %b, expected 0", rdy); end
    checks++; if (rdyn !== 1'b1) begin errors++; $display("FAIL sw_ready_after: got %b, expected 1", rdyn); end
    xact1(1'b0, 3'd3, 32'h40, 32'h0, rv, d, e, rdy, rdyn);
    checks++; if (rv !== 1'b1) begin errors++; $display("FAIL lw_rv: got %b, expected 1", rv); end
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h, expected deadbeef", d); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL lw_err: got %b, expected 0", e); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL lw_ready_resp: got %b, expected 0", rdy); end
    checks++; if (rdyn !== 1'b1) begin errors++; $display("FAIL lw_ready_after: got %b, expected 1", rdyn); end
  endtask

  task automatic test_subword();
    logic rv, e, rdy, rdyn;
    logic [31:0] d;
    xact1(1'b0, 3'd1, 32'h41, 32'h0, rv, d, e, rdy, rdyn);
    checks++; if (d !== 32'hFFFFFFBE) begin errors++; $display("FAIL lb: got %h, expected ffffffbe", d); end
    xact1(1'b0, 3'd5, 32'h41, 32'h0, rv, d, e, rdy, rdyn);
    checks++; if (d !== 32'h000000BE) begin errors++; $display("FAIL lbu: got %h, expected 000000be", d); end
    xact1(1'b0, 3'd2, 32'h42, 32'h0, rv, d, e, rdy, rdyn);
    checks++; if (d !== 32'hFFFFDEAD) begin errors++; $display("FAIL lh: got %h, expected ffffdead", d); end
    xact1(1'b0, 3'd6, 32'h42, 32'h0, rv, d, e, rdy, rdyn);
    checks++; if (d !== 32'h0000DEAD) begin errors++; $display("FAIL lhu: got %h, expected 0000dead", d); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL lhu_err: got %b, expected 0", e); end
    xact1(1'b0, 3'd1, 32'h40, 32'h0, rv, d, e, rdy, rdyn);
    checks++; if (d !== 32'hFFFFFFEF) begin errors++; $display("FAIL lb_lane0: got %h, expected ffffffef", d); end
  endtask

  task automatic test_masked_store();
    logic rv, e, rdy, rdyn;
    logic [31:0] d;
    xact1(1'b1, 3'd1, 32'h43, 32'h00000011, rv, d, e, rdy, rdyn);
    xact1(1'b0, 3'd3, 32'h40, 32'h0, rv, d, e, rdy, rdyn);
    checks++; if (d !== 32'h11ADBEEF) begin errors++; $display("FAIL sb_lane3: got %h, expected 11adbeef", d); end
    xact1(1'b1, 3'd2, 32'h40, 32'h00002233, rv, d, e, rdy, rdyn);
    xact1(1'b0, 3'd3, 32'h40, 32'h0, rv, d, e, rdy, rdyn);
    checks++; if (d !== 32'h11AD2233) begin errors++; $display("FAIL sh_low: got %h, expected 11ad2233", d); end
  endtask

  task automatic test_errors();
    logic rv, e, rdy, rdyn;
    logic [31:0] d;
    xact1(1'b0, 3'd3, 32'h42, 32'h0, rv, d, e, rdy, rdyn);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL lw_misaligned_err: got %b, expected 1", e); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL lw_misaligned_data: got %h, expected 00000000", d); end
    xact1(1'b1, 3'd2, 32'h41, 32'h0000FFFF, rv, d, e, rdy, rdyn);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL sh_misaligned_err: got %b, expected 1", e); end
    checks++; if (rv !== 1'b1) begin errors++; $display("FAIL sh_misaligned_rv: got %b, expected 1", rv); end
    xact1(1'b0, 3'd3, 32'h40, 32'h0, rv, d, e, rdy, rdyn);
    checks++; if (d !== 32'h11AD2233) begin errors++; $display("FAIL sh_misaligned_nowrite: got %h, expected 11ad2233", d); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL err_clears: got %b, expected 0", e); end
    xact1(1'b0, 3'd3, 32'h100, 32'h0, rv, d, e, rdy, rdyn);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL lw_oor_err: got %b, expected 1", e); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL lw_oor_data: got %h, expected 00000000", d); end
    xact1(1'b1, 3'd3, 32'hFC, 32'h0BADF00D, rv, d, e, rdy, rdyn);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL sw_lastword_err: got %b, expected 0", e); end
    xact1(1'b0, 3'd3, 32'hFC, 32'h0, rv, d, e, rdy, rdyn);
    checks++; if (d !== 32'h0BADF00D) begin errors++; $display("FAIL lw_lastword: got %h, expected 0badf00d", d); end
    xact1(1'b0, 3'd7, 32'h40, 32'h0, rv, d, e, rdy, rdyn);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL typ7_err: got %b, expected 1", e); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL typ7_data: got %h, expected 00000000", d); end
    xact1(1'b1, 3'd0, 32'h40, 32'hFFFFFFFF, rv, d, e, rdy, rdyn);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL typ0_store_err: got %b, expected 1", e); end
    xact1(1'b0, 3'd3, 32'h40, 32'h0, rv, d, e, rdy, rdyn);
    checks++; if (d !== 32'h11AD2233) begin errors++; $display("FAIL typ0_nowrite: got %h, expected 11ad2233", d); end
  endtask

  task automatic test_latency3();
    logic [7:0] exp_rdy = 8'b1000_1000;
    logic [7:0] exp_rv  = 8'b0100_0100;
    bus3.req_fcn   = 1'b1;
    bus3.req_typ   = 3'd3;
    bus3.req_addr  = 32'h1008;
    bus3.req_data  = 32'hCAFEF00D;
    bus3.req_valid = 1'b1;
    checks++; if (bus3.req_ready !== 1'b1) begin errors++; $display("FAIL l3_ready_pre: got %b, expected 1", bus3.req_ready); end
    @(posedge clk); #1;
    // Valid stays high with a load: ignored until the FSM returns to IDLE.
    bus3.req_fcn  = 1'b0;
    bus3.req_data = 32'h0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus3.req_ready !== exp_rdy[i]) begin errors++; $display("FAIL l3_ready[%0d]: got %b, expected %b", i, bus3.req_ready, exp_rdy[i]); end
      checks++; if (bus3.resp_valid !== exp_rv[i]) begin errors++; $display("FAIL l3_rv[%0d]: got %b, expected %b", i, bus3.resp_valid, exp_rv[i]); end
      if (i == 2) begin
        checks++; if (bus3.resp_data !== 32'h0) begin errors++; $display("FAIL l3_sw_data: got %h, expected 00000000", bus3.resp_data); end
      end
      if (i == 6) begin
        checks++; if (bus3.resp_data !== 32'hCAFEF00D) begin errors++; $display("FAIL l3_lw_data: got %h, expected cafef00d", bus3.resp_data); end
        checks++; if (bus3.err !== 1'b0) begin errors++; $display("FAIL l3_lw_err: got %b, expected 0", bus3.err); end
      end
      if (i == 4) bus3.req_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_errors3();
    logic seen, e;
    logic [31:0] d;
    int lat;
    xact3(1'b0, 3'd3, 32'h0FFC, 32'h0, seen, d, e, lat);
    checks++; if (seen !== 1'b1 || lat != 3) begin errors++; $display("FAIL l3_below_timing: got seen=%b lat=%0d, expected seen=1 lat=3", seen, lat); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL l3_below_err: got %b, expected 1", e); end
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL l3_below_data: got %h, expected 00000000", d); end
    xact3(1'b0, 3'd3, 32'h1100, 32'h0, seen, d, e, lat);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL l3_oor_err: got %b, expected 1", e); end
    xact3(1'b0, 3'd2, 32'h100A, 32'h0, seen, d, e, lat);
    checks++; if (seen !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL l3_lh_err: got seen=%b err=%b, expected seen=1 err=0", seen, e); end
    checks++; if (d !== 32'hFFFFCAFE) begin errors++; $display("FAIL l3_lh_data: got %h, expected ffffcafe", d); end
  endtask

  task automatic test_reset_midop();
    logic seen, e;
    logic [31:0] d;
    int lat;
    bus3.req_fcn   = 1'b0;
    bus3.req_typ   = 3'd3;
    bus3.req_addr  = 32'h1008;
    bus3.req_valid = 1'b1;
    @(posedge clk); #1;
    bus3.req_valid = 1'b0;
    checks++; if (bus3.req_ready !== 1'b0) begin errors++; $display("FAIL rst_busy_ready: got %b, expected 0", bus3.req_ready); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (bus3.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b, expected 1", bus3.req_ready); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus3.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_no_resp[%0d]: got %b, expected 0", i, bus3.resp_valid); end
      @(posedge clk); #1;
    end
    xact3(1'b0, 3'd3, 32'h1008, 32'h0, seen, d, e, lat);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rst_reload_timeout: got seen=%b, expected 1", seen); end
    checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL rst_reload_data: got %h, expected cafef00d", d); end
  endtask

  task automatic test_reset_with_valid();
    logic seen, e, rv, rdy, rdyn;
    logic [31:0] d;
    int lat;
    bus1.req_fcn  = 1'b1; bus1.req_typ = 3'd3; bus1.req_addr = 32'h40;   bus1.req_data = 32'h55555555;
    bus3.req_fcn  = 1'b1; bus3.req_typ = 3'd3; bus3.req_addr = 32'h1008; bus3.req_data = 32'h12345678;
    bus1.req_valid = 1'b1;
    bus3.req_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus1.req_valid = 1'b0;
    bus3.req_valid = 1'b0;
    checks++; if (bus3.req_ready !== 1'b1) begin errors++; $display("FAIL rstv_no_capture3: got %b, expected 1", bus3.req_ready); end
    checks++; if (bus1.resp_valid !== 1'b0) begin errors++; $display("FAIL rstv_no_resp1: got %b, expected 0", bus1.resp_valid); end
    xact3(1'b0, 3'd3, 32'h1008, 32'h0, seen, d, e, lat);
    checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL rstv_nowrite3: got %h, expected cafef00d", d); end
    xact1(1'b0, 3'd3, 32'h40, 32'h0, rv, d, e, rdy, rdyn);
    checks++; if (d !== 32'h11AD2233) begin errors++; $display("FAIL rstv_nowrite1: got %h, expected 11ad2233", d); end
  endtask

  initial begin
    bus1.req_addr = '0; bus1.req_data = '0; bus1.req_fcn = 1'b0; bus1.req_typ = '0; bus1.req_valid = 1'b0;
    bus3.req_addr = '0; bus3.req_data = '0; bus3.req_fcn = 1'b0; bus3.req_typ = '0; bus3.req_valid = 1'b0;
    test_reset();
    test_store_load();
    test_subword();
    test_masked_store();
    test_errors();
    test_latency3();
    test_errors3();
    test_reset_midop();
    test_reset_with_valid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sodor_dmem_responder.md
Name: sodor_dmem_responder

Overview:
- Data-memory responder for the Sodor 3-stage core's dmem request/response port.
- Accepts `req_valid`/`req_ready` handshaked load and store requests and holds a word-organised local RAM.
- Returns load data, sign- or zero-extended per `typ`, after a programmable fixed latency.
- Drives the core's `io_dmem_resp_*` and `io_dmem_req_ready` inputs in core-level benches.

Parameters:
- `DEPTH`, 1024, number of 32-bit words in the RAM (power of two).
- `BASE_ADDR`, 32'h0000_0000, byte address mapped to word 0.
- `LATENCY`, 1, cycles from accept edge to the `resp_valid` cycle (≥1).

Ports:
- `clock` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `dmem_in_io_dmem_req_bits_addr` in 32: byte address.
- `dmem_in_io_dmem_req_bits_data` in 32: store data, LSB-aligned.
- `dmem_in_io_dmem_req_bits_fcn` in 1: 0 = load (M_XRD), 1 = store (M_XWR).
- `dmem_in_io_dmem_req_bits_typ` in 3: 1=B, 2=H, 3=W, 5=BU, 6=HU; 0, 4 and 7 are illegal.
- `dmem_in_io_dmem_req_valid` in 1: request present.
- `dmem_ou_io_dmem_req_ready` out 1: responder can accept.
- `dmem_ou_io_dmem_resp_valid` out 1: one-cycle response pulse.
- `dmem_ou_io_dmem_resp_bits_data` out 32: load result.
- `dmem_ou_err` out 1: error flag, valid only with `resp_valid`.

Behaviour:
- Reset values:
  - `req_ready`=1, `resp_valid`=0, `resp_data`=0, `err`=0.
  - FSM goes to IDLE; latency counter is 0.
  - RAM contents are not cleared.
- FSM states: IDLE, BUSY, RESP.
  - IDLE: `req_ready`=1. On `valid&ready` (accept), capture addr/fcn/typ/data, compute error, go to BUSY if LATENCY>1 else RESP; counter = LATENCY-1.
  - BUSY: `req_ready`=0. Counter decrements each cycle; when it reaches 1, go to RESP.
  - RESP: `resp_valid`=1 for exactly this cycle, `req_ready`=0. Next state is IDLE.
- Timing and throughput:
  - Accept at edge N → `resp_valid` high in the cycle following edge N+LATENCY-1. With LATENCY=1, the response is the cycle right after accept.
  - Max throughput is one request per LATENCY+1 cycles.
  - `valid` while not ready is ignored (no capture, no side effect).
- Addressing:
  - offset = addr - BASE_ADDR; word index = offset[log2(DEPTH)+1:2]; byte lane = offset[1:0].
  - Out of range (addr < BASE_ADDR or offset ≥ DEPTH*4): `err`=1, store dropped, load data=0.
- Misalignment: H/HU with lane[0]=1, or W with lane≠0 → `err`=1, store dropped, load data=0.
- Illegal `typ` (0, 4, 7): `err`=1, no write, data=0.
- Stores:
  - Write occurs on the accept edge, so a following load sees it.
  - Byte-masked: B writes `data[7:0]` to the selected lane; H writes `data[15:0]` to lanes {1,0} or {3,2}; W writes all four lanes.
  - Store response still pulses `resp_valid` with data=0.
- Loads:
  - RAM read at accept; result is held in a pipeline/hold register until RESP.
  - Extraction: B sign-extends the selected byte, BU zero-extends it; H/HU do the same for the halfword; W returns the full word.
- `resp_bits_data` holds its last value outside RESP; benches check it only with `resp_valid`.
- Reset mid-operation: the pending response is discarded (no `resp_valid`), the FSM returns to IDLE next cycle, and a store already committed stays in RAM.
- Simultaneous reset and `valid` in the same cycle: reset wins and nothing is captured or written.

Test Plan:
- LATENCY=1: SW 32'hDEADBEEF @0x40 (fcn=1, typ=3), then LW @0x40 → `resp_valid` 1 cycle after each accept; load `resp_data`=32'hDEADBEEF, `err`=0; `req_ready` low exactly during the RESP cycle.
- With word 0x40=32'hDEADBEEF: LB @0x41 → 32'hFFFFFFBE; LBU @0x41 → 32'h000000BE; LH @0x42 → 32'hFFFFDEAD; LHU @0x42 → 32'h0000DEAD.
- SB 32'h00000011 @0x43, then LW @0x40 → 32'h11ADBEEF. SH 32'h00002233 @0x40, then LW @0x40 → 32'h11AD2233.
- LATENCY=3: LW accepted at edge N → `resp_valid` only in the cycle after edge N+2; `req_ready`=0 for 3 cycles; `valid` held high is re-accepted only in the cycle after RESP.
- Errors: LW @0x42 → `err`=1, data=0. SH @0x41 → `err`=1, RAM unchanged. LW @DEPTH*4 → `err`=1, data=0. typ=7 → `err`=1.
- Reset asserted in the BUSY cycle of a LATENCY=3 load → no `resp_valid` afterwards, `req_ready`=1 the cycle after reset deasserts, and prior stored data is still readable.
